// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding,
// frame geometry and line levels.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Single-clock byte FIFO feeding the transmitter;
// power-of-two depth so pointers wrap naturally.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/transmitter.sv
// Buffered UART transmitter: byte FIFO plus
// start/data/stop serializer with a registered TXD.
module transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TXD,
  output logic                 tx_busy
);

  localparam int STOP_CYC = CLKS_PER_BIT * STOP_BITS;
  localparam int CW = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic txd_q, txd_d;

  logic fifo_full, fifo_empty, pop;
  logic [DATA_BITS-1:0] fifo_head;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tx_valid & tx_ready),
    .wr_data (tx_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready = ~fifo_full;
  assign tx_busy  = (state_q != ST_IDLE) | ~fifo_empty;
  assign TXD      = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          // Chain straight into the next frame when data waits.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_START: txd_d = START_LVL;
      ST_DATA:  txd_d = shift_d[0];
      ST_STOP:  txd_d = STOP_LVL;
      default:  txd_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: three parameterisations checked
// every cycle against a frame-queue model, plus literals.
module tb_transmitter;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       txd      [3];
  logic       tx_busy  [3];

  transmitter dut0 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .TXD(txd[0]),
    .tx_busy(tx_busy[0])
  );

  transmitter #(
    .CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .TXD(txd[1]),
    .tx_busy(tx_busy[1])
  );

  transmitter #(
    .CLKS_PER_BIT(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut2 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .TXD(txd[2]),
    .tx_busy(tx_busy[2])
  );

  int cpb   [3] = '{1, 4, 2};
  int sbits [3] = '{1, 1, 2};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pending bytes and the list of line levels still to send.
  logic [7:0] pend [3][$];
  bit         line [3][$];
  logic m_txd [3];
  logic m_busy [3];
  logic m_ready [3];
  bit   m_ok = 0;

  task automatic step(int i);
    logic [7:0] b;
    bit acc, inf;
    if (!reset) begin
      pend[i].delete();
      line[i].delete();
      m_txd[i]   = 1'b1;
      m_busy[i]  = 1'b0;
      m_ready[i] = 1'b1;
      m_ok       = 1;
    end else begin
      acc = (tx_valid[i] === 1'b1) && (pend[i].size() < DEPTH);
      if (line[i].size() == 0 && pend[i].size() > 0) begin
        b = pend[i].pop_front();
        repeat (cpb[i]) line[i].push_back(1'b0);
        for (int k = 0; k < 8; k++)
          repeat (cpb[i]) line[i].push_back(b[k]);
        repeat (cpb[i] * sbits[i]) line[i].push_back(1'b1);
      end
      if (line[i].size() > 0) begin
        m_txd[i] = line[i].pop_front();
        inf = 1;
      end else begin
        m_txd[i] = 1'b1;
        inf = 0;
      end
      if (acc) pend[i].push_back(tx_data[i]);
      m_busy[i]  = inf || (pend[i].size() > 0);
      m_ready[i] = pend[i].size() < DEPTH;
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(i);
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("txd%0d", i), 32'(txd[i]), 32'(m_txd[i]));
        check($sformatf("busy%0d", i), 32'(tx_busy[i]),
              32'(m_busy[i]));
        check($sformatf("ready%0d", i), 32'(tx_ready[i]),
              32'(m_ready[i]));
      end
    end
  end

  // One-sample-per-clock receiver on dut0's line.
  int         rx_cnt = 0;
  logic [7:0] rx_data = 8'h00;
  initial begin
    int rs = 0;
    int k  = 0;
    logic [7:0] sh = 8'h00;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        rs = 0;
      end else begin
        case (rs)
          0: if (txd[0] === 1'b0) begin rs = 1; k = 0; end
          1: begin
            sh[k] = txd[0];
            k++;
            if (k == 8) rs = 2;
          end
          default: begin
            if (txd[0] === 1'b1) begin
              rx_data = sh;
              rx_cnt++;
            end
            rs = 0;
          end
        endcase
      end
    end
  end

  int busy_cnt1 = 0;
  initial forever begin
    @(negedge clk);
    if (tx_busy[1] === 1'b1) busy_cnt1++;
  end

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy[0] | tx_busy[1] | tx_busy[2]) !== 1'b0
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    logic [5:0] rdy;
    int n, lo, hi, base, lows, busys;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h99;
    repeat (3) @(negedge clk);
    tx_valid[0] = 1'b0;
    check("rst_txd", 32'(txd[0]), 32'd1);
    check("rst_busy", 32'(tx_busy[0]), 32'd0);
    check("rst_ready", 32'(tx_ready[0]), 32'd1);
    reset = 1'b1;

    // Single byte 0xA5
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hA5;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    check("a5_pre_idle", 32'(txd[0]), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seq[k] = txd[0];
    end
    check("a5_seq", 32'(seq), 32'(10'b1101001010));
    @(negedge clk);
    check("a5_after_txd", 32'(txd[0]), 32'd1);
    check("a5_after_busy", 32'(tx_busy[0]), 32'd0);
    wait_idle();

    // Six offers into a 4-deep FIFO at 4 clocks per bit
    busy_cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      tx_valid[1] = 1'b1;
      tx_data[1]  = 8'(k + 1);
      rdy[k]      = tx_ready[1];
      @(negedge clk);
    end
    tx_valid[1] = 1'b0;
    check("burst_ready", 32'(rdy), 32'(6'b011111));
    wait_idle();
    check("burst_busy_cycles", 32'(busy_cnt1), 32'd201);

    // Two stop bits, 2 clocks per bit, two 0x00 bytes
    tx_valid[2] = 1'b1;
    tx_data[2]  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    tx_valid[2] = 1'b0;
    n = 0;
    while (txd[2] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    lo = 0;
    while (txd[2] === 1'b0 && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    hi = 0;
    while (txd[2] === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("sb2_low_run", 32'(lo), 32'd18);
    check("sb2_high_run", 32'(hi), 32'd4);
    wait_idle();

    // Loopback into the receiver
    base = rx_cnt;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h3C;
    @(negedge clk);
    tx_data[0]  = 8'hFF;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    n = 0;
    while (rx_cnt < base + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("loop_rx0", 32'(rx_data), 32'h3C);
    n = 0;
    while (rx_cnt < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("loop_rx1", 32'(rx_data), 32'hFF);
    wait_idle();

    // Reset during bit 3 of 0x55 with two bytes behind it
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h55;
    @(negedge clk);
    tx_data[0]  = 8'h01;
    @(negedge clk);
    tx_data[0]  = 8'h02;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_bit3", 32'(txd[0]), 32'd0);
    check("abort_busy_pre", 32'(tx_busy[0]), 32'd1);
    reset = 1'b0;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h77;
    @(negedge clk);
    reset = 1'b1;
    tx_valid[0] = 1'b0;
    check("abort_txd", 32'(txd[0]), 32'd1);
    check("abort_busy", 32'(tx_busy[0]), 32'd0);
    check("abort_ready", 32'(tx_ready[0]), 32'd1);
    lows = 0;
    busys = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
      if (tx_busy[0] !== 1'b0) busys++;
    end
    check("abort_no_frames", 32'(lows), 32'd0);
    check("abort_stays_idle", 32'(busys), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
